// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Control layer that lets a 1-bit compare cell serve WIDTH-bit unsigned
//   operands. Operands are taken through a valid/ready handshake, scanned
//   MSB-first one bit per clock, and the one-hot Lt/Gt/Eq result is held
//   behind a second valid/ready handshake until the consumer takes it.
//
//   Build option: define SERIAL_CMP_EARLY_EXIT_EN to stop the scan on the
//   first mismatching bit. When it is undefined, every comparison scans all
//   WIDTH bits, which gives constant latency. The result flags are the same
//   in both builds.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  operands on A/B are valid
//   start_ready  block can accept operands (IDLE only)
//   A, B         WIDTH-bit unsigned operands, captured on accept
//   res_valid    result flags valid
//   res_ready    consumer accepts the result
//   Lt, Gt, Eq   one-hot result: A<B, A>B, A==B
//   busy         high while scanning or holding a result
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             Lt,
  output logic             Gt,
  output logic             Eq,
  output logic             busy
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_lt;
  logic             r_gt;
  logic             r_resLt;
  logic             r_resGt;
  logic             r_resEq;

  logic             w_accept;
  logic             w_consume;
  logic             w_cellLt;
  logic             w_cellGt;
  logic             w_newLt;
  logic             w_newGt;
  logic             w_scanEnd;

  assign w_accept  = (r_state == IDLE) && start_valid;
  assign w_consume = (r_state == DONE) && res_ready;

  // The operand registers shift left each scan cycle, so the bit at the
  // current index always sits in the MSB position. This keeps the 1-bit
  // cell on a fixed tap instead of a WIDTH-way mux.
  assign w_cellGt = r_a[WIDTH-1] & ~r_b[WIDTH-1];
  assign w_cellLt = ~r_a[WIDTH-1] & r_b[WIDTH-1];

  // Sticky flags: only the first (most significant) mismatch is recorded.
  assign w_newGt = r_gt | (~(r_lt | r_gt) & w_cellGt);
  assign w_newLt = r_lt | (~(r_lt | r_gt) & w_cellLt);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_scanEnd = (r_idx == '0) || w_cellGt || w_cellLt;
`else
  assign w_scanEnd = (r_idx == '0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A result hand-off and a new start never share a
  // cycle: DONE always returns to IDLE first.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_nextState = SCAN;
      SCAN:    if (w_scanEnd) w_nextState = DONE;
      DONE:    if (w_consume) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output
  // combinationally.
  always_comb begin
    start_ready = (r_state == IDLE);
    busy        = (r_state != IDLE);
    res_valid   = (r_state == DONE);
    Lt          = r_resLt;
    Gt          = r_resGt;
    Eq          = r_resEq;
  end

  // Datapath: operand capture, bit scan and result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= LAST_IDX;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
      r_resLt <= 1'b0;
      r_resGt <= 1'b0;
      r_resEq <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_idx <= LAST_IDX;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
          end
        end
        SCAN: begin
          r_lt <= w_newLt;
          r_gt <= w_newGt;
          r_a  <= r_a << 1;
          r_b  <= r_b << 1;
          if (w_scanEnd) begin
            r_resLt <= w_newLt;
            r_resGt <= w_newGt;
            r_resEq <= ~(w_newLt | w_newGt);
          end else begin
            // Scan ends at index 0, so this never wraps.
            r_idx <= r_idx - IDXW'(1);
          end
        end
        DONE: begin
          if (w_consume) begin
            r_resLt <= 1'b0;
            r_resGt <= 1'b0;
            r_resEq <= 1'b0;
          end
        end
        default: begin
          r_resLt <= 1'b0;
          r_resGt <= 1'b0;
          r_resEq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl
//   Directed and random-operand bench for serial_compare_ctrl, with one
//   WIDTH=8 instance and one WIDTH=1 instance sharing clock and reset.
//   Expected latency follows SERIAL_CMP_EARLY_EXIT_EN when it is defined.
module tb_serial_compare_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       startValid8 = 1'b0;
  logic       startReady8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       resValid8;
  logic       resReady8 = 1'b1;
  logic       lt8, gt8, eq8, busy8;

  logic       startValid1 = 1'b0;
  logic       startReady1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       resValid1;
  logic       resReady1 = 1'b1;
  logic       lt1, gt1, eq1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(startValid8), .start_ready(startReady8),
    .A(a8), .B(b8),
    .res_valid(resValid8), .res_ready(resReady8),
    .Lt(lt8), .Gt(gt8), .Eq(eq8), .busy(busy8)
  );

  serial_compare_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(startValid1), .start_ready(startReady1),
    .A(a1), .B(b1),
    .res_valid(resValid1), .res_ready(resReady1),
    .Lt(lt1), .Gt(gt1), .Eq(eq1), .busy(busy1)
  );

  // Number of edges from accept to res_valid for an 8-bit pair.
  function automatic int expLat8(input logic [7:0] a, input logic [7:0] b);
    int m;
    m = 8;
    for (int i = 7; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        m = 8 - i;
        break;
      end
    end
    return EARLY ? m : 8;
  endfunction

  // Presents one operand pair to the 8-bit instance and returns the
  // observed latency and flags; consumes the result when res_ready is high.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [2:0] flags);
    int waitN;
    @(negedge clk);
    waitN = 0;
    while (!startReady8 && waitN < 20) begin
      @(negedge clk);
      waitN++;
    end
    if (!startReady8) begin
      checks++;
      errors++;
      $display("[TB] FAIL start_accept8: start_ready=%0b required 1", startReady8);
    end
    a8 = a;
    b8 = b;
    startValid8 = 1'b1;
    @(posedge clk);
    #1;
    startValid8 = 1'b0;
    lat = 0;
    while (!resValid8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    flags = {lt8, gt8, eq8};
    if (resReady8) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive1(input logic a, input logic b,
                        output int lat, output logic [2:0] flags);
    int waitN;
    @(negedge clk);
    waitN = 0;
    while (!startReady1 && waitN < 20) begin
      @(negedge clk);
      waitN++;
    end
    if (!startReady1) begin
      checks++;
      errors++;
      $display("[TB] FAIL start_accept1: start_ready=%0b required 1", startReady1);
    end
    a1 = a;
    b1 = b;
    startValid1 = 1'b1;
    @(posedge clk);
    #1;
    startValid1 = 1'b0;
    lat = 0;
    while (!resValid1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    flags = {lt1, gt1, eq1};
    if (resReady1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #4;
    checks++;
    if ({startReady8, resValid8, lt8, gt8, eq8, busy8} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset8: got rdy/val/lt/gt/eq/busy=%b required 100000",
               {startReady8, resValid8, lt8, gt8, eq8, busy8});
    end
    checks++;
    if ({startReady1, resValid1, lt1, gt1, eq1, busy1} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset1: got rdy/val/lt/gt/eq/busy=%b required 100000",
               {startReady1, resValid1, lt1, gt1, eq1, busy1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Shared body for the directed 8-bit cases.
  task automatic test_directed(input string name, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] expFlags);
    int lat;
    logic [2:0] flags;
    resReady8 = 1'b1;
    drive8(a, b, lat, flags);
    checks++;
    if (flags !== expFlags) begin
      errors++;
      $display("[TB] FAIL %s_flags: got lt/gt/eq=%b required %b", name, flags, expFlags);
    end
    checks++;
    if (lat != expLat8(a, b)) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d required %0d", name, lat, expLat8(a, b));
    end
  endtask

  task automatic test_equal();
    test_directed("equal", 8'h5A, 8'h5A, 3'b001);
  endtask

  task automatic test_msb_mismatch();
    test_directed("msb", 8'h80, 8'h7F, 3'b010);
  endtask

  task automatic test_lsb_mismatch();
    test_directed("lsb", 8'h12, 8'h13, 3'b100);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [2:0] flags;
    resReady8 = 1'b0;
    drive8(8'h33, 8'h44, lat, flags);
    checks++;
    if (flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL bp_flags: got lt/gt/eq=%b required 100", flags);
    end
    // Hold the result for five cycles while offering a conflicting start.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a8 = 8'hFF;
      b8 = 8'h00;
      startValid8 = (c == 1 || c == 2);
      @(posedge clk);
      #1;
      checks++;
      if ({resValid8, lt8, gt8, eq8, startReady8, busy8} !== 6'b110001) begin
        errors++;
        $display("[TB] FAIL bp_hold c=%0d: got val/lt/gt/eq/rdy/busy=%b required 110001",
                 c, {resValid8, lt8, gt8, eq8, startReady8, busy8});
      end
    end
    @(negedge clk);
    startValid8 = 1'b0;
    resReady8 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({startReady8, resValid8, lt8, gt8, eq8, busy8} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL bp_release: got rdy/val/lt/gt/eq/busy=%b required 100000",
               {startReady8, resValid8, lt8, gt8, eq8, busy8});
    end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    a8 = 8'hF0;
    b8 = 8'h0F;
    startValid8 = 1'b1;
    @(posedge clk);
    #1;
    startValid8 = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midscan_busy: got %b required 1", busy8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({startReady8, resValid8, lt8, gt8, eq8, busy8} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL midscan_reset: got rdy/val/lt/gt/eq/busy=%b required 100000",
               {startReady8, resValid8, lt8, gt8, eq8, busy8});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_directed("after_reset", 8'h01, 8'h02, 3'b100);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2:0] flags;
    logic [2:0] expFlags;
    logic [7:0] a;
    logic [7:0] b;
    logic x;
    logic y;
    resReady8 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = 8'($urandom_range(0, 255));
      b = (n % 8 == 0) ? a : 8'($urandom_range(0, 255));
      drive8(a, b, lat, flags);
      expFlags = {a < b, a > b, a == b};
      checks++;
      if (flags !== expFlags) begin
        errors++;
        $display("[TB] FAIL b2b8_flags a=%h b=%h: got %b required %b", a, b, flags, expFlags);
      end
      checks++;
      if ($countones(flags) != 1) begin
        errors++;
        $display("[TB] FAIL b2b8_onehot a=%h b=%h: got %b required one-hot", a, b, flags);
      end
      checks++;
      if (lat != expLat8(a, b)) begin
        errors++;
        $display("[TB] FAIL b2b8_latency a=%h b=%h: got %0d required %0d",
                 a, b, lat, expLat8(a, b));
      end
    end
    for (int n = 0; n < 40; n++) begin
      x = 1'($urandom_range(0, 1));
      y = 1'($urandom_range(0, 1));
      drive1(x, y, lat, flags);
      expFlags = {(!x && y), (x && !y), (x == y)};
      checks++;
      if (flags !== expFlags) begin
        errors++;
        $display("[TB] FAIL b2b1_flags a=%b b=%b: got %b required %b", x, y, flags, expFlags);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("[TB] FAIL b2b1_latency a=%b b=%b: got %0d required 1", x, y, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb_mismatch();
    test_lsb_mismatch();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
